flex_stp_deser: RTL and testbench
=================================

// Module: flex_stp_deser
// PURPOSE
//  Multi-lane serial-to-parallel deserializer with word framing and a valid/ready output stage.
//  Each lane shifts in one bit per enabled cycle. After NUM_BITS enabled cycles, all lanes
//  present one complete word together. The block sits between serial sample links and the FFT
//  input buffer, and reports lost words when the downstream stage stalls.
// PARAMETERS
//  NUM_BITS   16  bits per word, per lane (>= 2)
//  NUM_LANES  2   independent serial lanes, sharing one bit counter
//  SHIFT_MSB  1   1: first received bit lands in the word MSB; 0: first received bit lands in the LSB
// PORTS
//  clk            in   1                    system clock
//  n_rst          in   1                    reset, asynchronous, active-low
//  clear          in   1                    synchronous flush of the partial word, valid and overrun
//  shift_enable   in   1                    sample serial_in on this edge
//  serial_in      in   NUM_LANES            one bit per lane; lane k = serial_in[k]
//  bit_count      out  $clog2(NUM_BITS)     bits received in the current partial word
//  word_done      out  1                    1-cycle pulse, the cycle after a word completes
//  parallel_out   out  NUM_LANES*NUM_BITS   lane k word = parallel_out[k*NUM_BITS +: NUM_BITS]
//  out_valid      out  1                    parallel_out holds an unconsumed word
//  out_ready      in   1                    downstream accepts the word when out_valid && out_ready
//  overrun        out  1                    sticky: a completed word was dropped
// BEHAVIOUR
//  Reset (n_rst=0, async):
//   - per-lane shift registers = all 1s (idle line level)
//   - parallel_out = all 1s; bit_count = 0
//   - out_valid, word_done, overrun = 0
//  clear=1 (sync): same values as reset on the next edge. clear has priority over shift_enable
//   and out_ready.
//  Shift (shift_enable=1):
//   - SHIFT_MSB=1: sr_k <= {sr_k[NUM_BITS-2:0], serial_in[k]}
//   - SHIFT_MSB=0: sr_k <= {serial_in[k], sr_k[NUM_BITS-1:1]}
//   - bit_count increments by 1.
//   - shift_enable=0: shift registers and bit_count hold; gaps of any length are allowed.
//  Completion: an edge with shift_enable=1 and bit_count==NUM_BITS-1.
//   - bit_count wraps to 0.
//   - The completed word includes the bit sampled on this edge.
//  Output stage: one holding register.
//   - Accept = out_valid && out_ready.
//   - On completion, if !out_valid || out_ready: parallel_out <= completed words of all lanes,
//     out_valid <= 1, word_done <= 1 on the next cycle.
//     Latency: 1 clk from the final bit's edge to out_valid/data.
//   - On completion, if out_valid && !out_ready: new word dropped, parallel_out unchanged,
//     overrun <= 1, word_done <= 1.
//   - Accept with no completion: out_valid <= 0 and parallel_out holds its last value.
//   - Completion and accept in the same cycle: the new word loads, out_valid stays 1,
//     no overrun, and the new word counts as a fresh transfer.
//  Stability: parallel_out never changes while out_valid=1 && out_ready=0.
//  overrun clears only on reset or clear.
//  Reset or clear mid-word discards the partial word; the next word starts at bit 0.
//  Outputs are registered. No combinational path from any input to any output.
// TESTING (NUM_BITS=8, NUM_LANES=2 unless noted)
//  1. SHIFT_MSB=1; lane0 sends 0xA5 MSB-first, lane1 sends 0x3C, 8 consecutive enables
//     -> next cycle: out_valid=1, word_done=1 for 1 cycle, parallel_out=16'h3CA5.
//  2. SHIFT_MSB=0; lanes send 0xA5 and 0x3C LSB-first, with 3 idle cycles inserted after bit 4
//     -> parallel_out=16'h3CA5; bit_count holds at 4 through the gap.
//  3. out_ready=0; send 0x11/0x22, then 0x33/0x44
//     -> parallel_out stays 16'h2211, overrun=1 after the second completion;
//        raise out_ready -> out_valid=0 next cycle.
//  4. out_ready=1 on exactly the completion edge of word 2 (0x55/0x66) while word 1 is valid
//     -> out_valid stays 1, parallel_out=16'h6655, overrun=0.
//  5. Assert n_rst after 3 bits, then clear after 5 bits on a separate run
//     -> outputs at reset values (parallel_out=16'hFFFF, bit_count=0);
//        the following full word 0x81/0x7E is received as 16'h7E81.
//  6. Randomised: NUM_LANES=4, NUM_BITS=12, random enables and ready
//     -> scoreboard shows every accepted word matches the sent word;
//        overrun is set iff some word was dropped.

Source files
------------

// File: rtl/flex_stp_deser.sv
// Multi-lane serial-to-parallel deserializer with shared bit counter,
// word framing and a single-entry valid/ready holding register.
module flex_stp_deser #(
   parameter  int unsigned NUM_BITS  = 16,
   parameter  int unsigned NUM_LANES = 2,
   parameter  int unsigned SHIFT_MSB = 1,
   localparam int unsigned CNT_W     = $clog2(NUM_BITS),
   localparam int unsigned WORD_W    = NUM_LANES * NUM_BITS
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 clear,
   input  logic                 shift_enable,
   input  logic [NUM_LANES-1:0] serial_in,
   output logic [CNT_W-1:0]     bit_count,
   output logic                 word_done,
   output logic [WORD_W-1:0]    parallel_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 overrun
);

   // Each lane keeps only NUM_BITS-1 bits of history: the bit that would be
   // shifted out is never observable, and the completed word is formed from
   // the stored history plus the bit sampled on the completing edge.
   localparam int unsigned SR_W    = NUM_BITS - 1;
   localparam int unsigned SR_ALLW = NUM_LANES * SR_W;

   logic [SR_ALLW-1:0] sr;
   logic [SR_ALLW-1:0] sr_next;
   logic [WORD_W-1:0]  word_c;
   logic               word_complete;
   logic               can_load;
   logic               accept;

   // Per-lane word assembly: history plus the incoming bit, in the configured order.
   for (genvar lane = 0; lane < NUM_LANES; lane++) begin : g_lane
      if (SHIFT_MSB != 0) begin : g_msb
         assign word_c[lane*NUM_BITS +: NUM_BITS] = {sr[lane*SR_W +: SR_W], serial_in[lane]};
         assign sr_next[lane*SR_W +: SR_W]        = word_c[lane*NUM_BITS +: SR_W];
      end else begin : g_lsb
         assign word_c[lane*NUM_BITS +: NUM_BITS] = {serial_in[lane], sr[lane*SR_W +: SR_W]};
         assign sr_next[lane*SR_W +: SR_W]        = word_c[lane*NUM_BITS + 1 +: SR_W];
      end
   end

   assign word_complete = shift_enable && (bit_count == CNT_W'(NUM_BITS - 1));
   assign accept        = out_valid && out_ready;
   assign can_load      = !out_valid || out_ready;

   // Shift history, bit counter, holding register and status flags.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sr           <= '1;
         bit_count    <= '0;
         parallel_out <= '1;
         out_valid    <= 1'b0;
         word_done    <= 1'b0;
         overrun      <= 1'b0;
      end else if (clear) begin
         sr           <= '1;
         bit_count    <= '0;
         parallel_out <= '1;
         out_valid    <= 1'b0;
         word_done    <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         word_done <= word_complete;
         if (shift_enable) begin
            sr        <= sr_next;
            bit_count <= word_complete ? '0 : bit_count + CNT_W'(1);
         end
         if (word_complete) begin
            if (can_load) begin
               parallel_out <= word_c;
               out_valid    <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (accept) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_flex_stp_deser.sv
// Scoreboard bench: two 8-bit/2-lane instances (MSB-first and LSB-first, fed
// the same words in their respective bit order) plus a 12-bit/4-lane instance
// exercised with random enables and ready.
module tb_flex_stp_deser;

   localparam int unsigned NBC = 12;
   localparam int unsigned NLC = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        n_rst, clear, se, out_ready;
   logic [1:0]  a_ser, b_ser;
   logic [2:0]  a_cnt, b_cnt;
   logic        a_done, b_done, a_valid, b_valid, a_ovr, b_ovr;
   logic [15:0] a_par, b_par;

   logic        c_se, c_ready;
   logic [3:0]  c_ser, c_cnt;
   logic        c_done, c_valid, c_ovr;
   logic [47:0] c_par;

   flex_stp_deser #(.NUM_BITS(8), .NUM_LANES(2), .SHIFT_MSB(1)) u_a (
      .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(se), .serial_in(a_ser),
      .bit_count(a_cnt), .word_done(a_done), .parallel_out(a_par), .out_valid(a_valid),
      .out_ready(out_ready), .overrun(a_ovr));

   flex_stp_deser #(.NUM_BITS(8), .NUM_LANES(2), .SHIFT_MSB(0)) u_b (
      .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(se), .serial_in(b_ser),
      .bit_count(b_cnt), .word_done(b_done), .parallel_out(b_par), .out_valid(b_valid),
      .out_ready(out_ready), .overrun(b_ovr));

   flex_stp_deser #(.NUM_BITS(NBC), .NUM_LANES(NLC), .SHIFT_MSB(1)) u_c (
      .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(c_se), .serial_in(c_ser),
      .bit_count(c_cnt), .word_done(c_done), .parallel_out(c_par), .out_valid(c_valid),
      .out_ready(c_ready), .overrun(c_ovr));

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] q_a[$];
   logic [15:0] q_b[$];
   logic [47:0] q_c[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Monitors: an accept happens on the next rising edge whenever valid && ready here.
   always @(negedge clk) begin
      if (n_rst && !clear && a_valid && out_ready) begin
         if (q_a.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL a_unexpected_word: got %0h want none", a_par);
         end else check("a_word", 64'(a_par), 64'(q_a.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (n_rst && !clear && b_valid && out_ready) begin
         if (q_b.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL b_unexpected_word: got %0h want none", b_par);
         end else check("b_word", 64'(b_par), 64'(q_b.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (n_rst && !clear && c_valid && c_ready) begin
         if (q_c.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL c_unexpected_word: got %0h want none", c_par);
         end else check("c_word", 64'(c_par), 64'(q_c.pop_front()));
      end
   end

   task automatic push_ab(input logic [15:0] w);
      q_a.push_back(w);
      q_b.push_back(w);
   endtask

   // Sends nbits of lane words w0/w1 on both 8-bit instances; optional 3-cycle
   // gap after gap_after bits; optional ready pulse on the last bit's edge only.
   task automatic send_word(input logic [7:0] w0, input logic [7:0] w1, input int nbits,
                            input int gap_after, input bit rdy_last);
      for (int i = 0; i < nbits; i++) begin
         a_ser = {w1[7-i], w0[7-i]};
         b_ser = {w1[i], w0[i]};
         se    = 1'b1;
         if (rdy_last && i == nbits - 1) out_ready = 1'b1;
         tick;
         if (rdy_last && i == nbits - 1) out_ready = 1'b0;
         if (i + 1 == gap_after) begin
            se = 1'b0;
            repeat (3) begin
               tick;
               check("a_gap_count", 64'(a_cnt), 64'(gap_after));
               check("b_gap_count", 64'(b_cnt), 64'(gap_after));
            end
         end
      end
      se = 1'b0;
   endtask

   task automatic check_ab_idle(input string tag);
      check({tag, "_a_par"}, 64'(a_par), 64'h0000_0000_0000_FFFF);
      check({tag, "_b_par"}, 64'(b_par), 64'h0000_0000_0000_FFFF);
      check({tag, "_a_cnt"}, 64'(a_cnt), 64'd0);
      check({tag, "_b_cnt"}, 64'(b_cnt), 64'd0);
      check({tag, "_a_valid"}, 64'(a_valid), 64'd0);
      check({tag, "_b_valid"}, 64'(b_valid), 64'd0);
      check({tag, "_a_ovr"}, 64'(a_ovr), 64'd0);
      check({tag, "_b_ovr"}, 64'(b_ovr), 64'd0);
   endtask

   initial begin
      bit          m_valid;
      bit          m_ovr;
      bit          en, rdy, cmpl;
      logic [47:0] word;
      int          bi;

      n_rst = 1'b0; clear = 1'b0; se = 1'b0; out_ready = 1'b0;
      a_ser = '0; b_ser = '0;
      c_se = 1'b0; c_ready = 1'b0; c_ser = '0;

      // Reset state
      #12;
      check_ab_idle("reset");
      check("reset_a_done", 64'(a_done), 64'd0);
      check("reset_c_par", 64'(c_par), 64'h0000_FFFF_FFFF_FFFF);
      check("reset_c_valid", 64'(c_valid), 64'd0);
      #1 n_rst = 1'b1;
      tick;

      // 1: consecutive enables, word_done pulse and 1-cycle latency
      out_ready = 1'b1;
      push_ab(16'h3CA5);
      send_word(8'hA5, 8'h3C, 8, 0, 1'b0);
      check("t1_a_valid", 64'(a_valid), 64'd1);
      check("t1_b_valid", 64'(b_valid), 64'd1);
      check("t1_a_done", 64'(a_done), 64'd1);
      check("t1_b_done", 64'(b_done), 64'd1);
      tick;
      check("t1_a_done_pulse", 64'(a_done), 64'd0);
      check("t1_b_done_pulse", 64'(b_done), 64'd0);

      // 2: idle gap after bit 4, bit_count holds
      push_ab(16'h3CA5);
      send_word(8'hA5, 8'h3C, 8, 4, 1'b0);
      tick;
      check("t2_a_valid_after_accept", 64'(a_valid), 64'd0);

      // 3: stall, second word dropped, overrun sticky until clear
      out_ready = 1'b0;
      push_ab(16'h2211);
      send_word(8'h11, 8'h22, 8, 0, 1'b0);
      send_word(8'h33, 8'h44, 8, 0, 1'b0);
      check("t3_a_ovr", 64'(a_ovr), 64'd1);
      check("t3_b_ovr", 64'(b_ovr), 64'd1);
      check("t3_a_par_stable", 64'(a_par), 64'h2211);
      check("t3_b_par_stable", 64'(b_par), 64'h2211);
      check("t3_a_done_on_drop", 64'(a_done), 64'd1);
      out_ready = 1'b1;
      tick;
      check("t3_a_valid_drained", 64'(a_valid), 64'd0);
      check("t3_b_valid_drained", 64'(b_valid), 64'd0);
      check("t3_a_ovr_sticky", 64'(a_ovr), 64'd1);
      clear = 1'b1;
      tick;
      clear = 1'b0;
      check("t3_a_ovr_cleared", 64'(a_ovr), 64'd0);

      // 4: completion and accept on the same edge
      out_ready = 1'b0;
      push_ab(16'h3412);
      send_word(8'h12, 8'h34, 8, 0, 1'b0);
      push_ab(16'h6655);
      send_word(8'h55, 8'h66, 8, 0, 1'b1);
      check("t4_a_valid", 64'(a_valid), 64'd1);
      check("t4_b_valid", 64'(b_valid), 64'd1);
      check("t4_a_par", 64'(a_par), 64'h6655);
      check("t4_b_par", 64'(b_par), 64'h6655);
      check("t4_a_ovr", 64'(a_ovr), 64'd0);
      check("t4_b_ovr", 64'(b_ovr), 64'd0);
      out_ready = 1'b1;
      tick;
      check("t4_a_valid_drained", 64'(a_valid), 64'd0);

      // 5a: async reset mid-word
      send_word(8'hFF, 8'h00, 3, 0, 1'b0);
      n_rst = 1'b0;
      #2;
      check_ab_idle("t5_rst");
      n_rst = 1'b1;
      tick;
      // 5b: clear mid-word after a held word
      push_ab(16'hC35A);
      send_word(8'h5A, 8'hC3, 8, 0, 1'b0);
      tick;
      check("t5_a_par_hold", 64'(a_par), 64'hC35A);
      check("t5_b_par_hold", 64'(b_par), 64'hC35A);
      send_word(8'h00, 8'hFF, 5, 0, 1'b0);
      check("t5_a_partial_cnt", 64'(a_cnt), 64'd5);
      clear = 1'b1;
      tick;
      clear = 1'b0;
      check_ab_idle("t5_clr");
      push_ab(16'h7E81);
      send_word(8'h81, 8'h7E, 8, 0, 1'b0);
      tick;
      check("t5_a_valid_drained", 64'(a_valid), 64'd0);

      // 6: random enables and ready on the 12-bit, 4-lane instance
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      for (int w = 0; w < 40; w++) begin
         word = 48'({$urandom(), $urandom()});
         bi = 0;
         while (bi < int'(NBC)) begin
            en  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) == 0);
            c_se    = en;
            c_ready = rdy;
            for (int k = 0; k < int'(NLC); k++) c_ser[k] = word[k*NBC + NBC - 1 - bi];
            cmpl = en && (bi == int'(NBC) - 1);
            if (cmpl) begin
               if (!m_valid || rdy) begin
                  q_c.push_back(word);
                  m_valid = 1'b1;
               end else begin
                  m_ovr = 1'b1;
               end
            end else if (m_valid && rdy) begin
               m_valid = 1'b0;
            end
            tick;
            if (en) bi++;
         end
      end
      c_se    = 1'b0;
      c_ready = 1'b1;
      repeat (3) tick;
      check("t6_c_ovr", 64'(c_ovr), 64'(m_ovr));
      check("t6_c_valid_drained", 64'(c_valid), 64'd0);

      check("a_queue_drained", 64'(q_a.size()), 64'd0);
      check("b_queue_drained", 64'(q_b.size()), 64'd0);
      check("c_queue_drained", 64'(q_c.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
